// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_block_if.sv
// Valid/ready word handshake between the host/FIFO side and the UART transmitter.
interface uart_tx_block_if #(parameter int unsigned NUM_DATA_BITS = 8);

    logic                     tx_valid;
    logic [NUM_DATA_BITS-1:0] tx_data;
    logic                     tx_ready;

    modport master (output tx_valid, output tx_data, input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, output tx_ready);

endinterface

// File: rtl/flex_counter.sv
// Free-running counter 0..rollover_val-1 with a registered flag marking the final count.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_nx;

    always_comb begin
        count_nx = count_out;
        if (clear) begin
            count_nx = '0;
        end else if (count_enable) begin
            count_nx = (count_out == rollover_val - ONE) ? '0 : count_out + ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count_out     <= count_nx;
            rollover_flag <= (count_nx == rollover_val - ONE);
        end
    end

endmodule

// File: rtl/uart_tx_block.sv
// UART transmitter: start bit, NUM_DATA_BITS data bits LSB-first, stop bit, then a
// one-cycle tx_done pulse. All outputs are registered.
module uart_tx_block
    import uart_pkg::*;
#(
    parameter int unsigned NUM_DATA_BITS = 8,
    parameter int unsigned BIT_PERIOD    = 10
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    uart_tx_block_if.slave  tx_if,
    output logic            tx_busy,
    output logic            tx_done,
    output logic            serial_out
);

    localparam int unsigned TW = $clog2(BIT_PERIOD + 1);
    localparam int unsigned IW = $clog2(NUM_DATA_BITS + 1);
    localparam logic [TW-1:0] TIMER_ROLL = TW'(BIT_PERIOD);
    localparam logic [IW-1:0] INDEX_ROLL = IW'(NUM_DATA_BITS);

    tx_state_t                state;
    logic [NUM_DATA_BITS-1:0] shift;
    logic [NUM_DATA_BITS-1:0] shift_nx;
    logic                     tx_ready_q;
    logic                     timer_en, timer_clear, timer_flag, bit_end;
    logic                     idx_en, idx_clear, idx_flag;
    logic [TW-1:0]            timer_cnt;
    logic [IW-1:0]            idx_cnt;
    logic                     unused_cnt;

    // Every in-frame transition happens on a bit end, where the timer has already
    // wrapped to 0, so holding it clear outside the frame covers every state entry.
    assign timer_en    = (state == START) || (state == DATA) || (state == STOP);
    assign timer_clear = clear || !timer_en;
    assign bit_end     = timer_flag && timer_en;
    assign idx_en      = (state == DATA) && bit_end;
    assign idx_clear   = clear || (state != DATA);
    assign shift_nx    = shift >> 1;
    assign unused_cnt  = ^{timer_cnt, idx_cnt};

    assign tx_if.tx_ready = tx_ready_q;

    flex_counter #(.NUM_CNT_BITS(TW)) u_bit_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (timer_clear),
        .count_enable (timer_en),
        .rollover_val (TIMER_ROLL),
        .count_out    (timer_cnt),
        .rollover_flag(timer_flag)
    );

    flex_counter #(.NUM_CNT_BITS(IW)) u_bit_index (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (idx_clear),
        .count_enable (idx_en),
        .rollover_val (INDEX_ROLL),
        .count_out    (idx_cnt),
        .rollover_flag(idx_flag)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            shift      <= '0;
            serial_out <= LINE_IDLE;
            tx_ready_q <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            shift      <= '0;
            serial_out <= LINE_IDLE;
            tx_ready_q <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (tx_if.tx_valid) begin
                        shift      <= tx_if.tx_data;
                        serial_out <= START_BIT;
                        tx_ready_q <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        serial_out <= shift[0];
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift <= shift_nx;
                        if (idx_flag) begin
                            serial_out <= STOP_BIT;
                            state      <= STOP;
                        end else begin
                            serial_out <= shift_nx[0];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    tx_done    <= 1'b0;
                    tx_ready_q <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: frames checked cycle by cycle against a waveform model
// derived from the frame format (start, LSB-first data, stop, done pulse).
module tb_uart_tx_block;

    localparam int unsigned N     = 8;
    localparam int unsigned P     = 10;
    localparam int unsigned FRAME = (N + 2) * P;

    logic tb_clk = 1'b0;
    logic n_rst  = 1'b1;
    logic clear  = 1'b0;
    logic tx_busy, tx_done, serial_out;

    int total     = 0;
    int bad       = 0;
    int done_seen = 0;

    uart_tx_block_if #(.NUM_DATA_BITS(N)) tx_if ();

    uart_tx_block #(.NUM_DATA_BITS(N), .BIT_PERIOD(P)) dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .tx_if     (tx_if),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .serial_out(serial_out)
    );

    always #5 tb_clk = ~tb_clk;

    always @(negedge tb_clk) if (tx_done === 1'b1) done_seen++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    // Expected line level c cycles after the accepting edge (1-based).
    function automatic logic exp_line(input logic [N-1:0] d, input int unsigned c);
        logic [N-1:0] dv;
        if (c <= P) return 1'b0;
        if (c <= (N + 1) * P) begin
            dv = d >> ((c - P - 1) / P);
            return dv[0];
        end
        return 1'b1;
    endfunction

    // Called at a negedge while idle; sends d and checks every cycle up to last_cycle.
    task automatic run_frame(input logic [N-1:0] d, input logic [N-1:0] mid_d,
                             input bit hold_valid, input int unsigned last_cycle);
        logic el, eb, ed;
        total++;
        if (tx_if.tx_ready !== 1'b1 || serial_out !== 1'b1) begin
            bad++;
            $display("FAIL idle_before_accept: ready=%b line=%b required ready=1 line=1",
                     tx_if.tx_ready, serial_out);
        end
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d;
        for (int unsigned c = 1; c <= last_cycle; c++) begin
            @(negedge tb_clk);
            el = (c <= FRAME) ? exp_line(d, c) : 1'b1;
            eb = (c <= FRAME);
            ed = (c == FRAME + 1);
            total++;
            if ({serial_out, tx_busy, tx_done, tx_if.tx_ready} !== {el, eb, ed, 1'b0}) begin
                bad++;
                $display("FAIL frame_cycle c=%0d data=%h: line/busy/done/ready=%b%b%b%b required %b%b%b0",
                         c, d, serial_out, tx_busy, tx_done, tx_if.tx_ready, el, eb, ed);
            end
            if (c == 1 && !hold_valid) tx_if.tx_valid = 1'b0;
            if (c == FRAME / 2) tx_if.tx_data = mid_d;
        end
    endtask

    task automatic test_reset;
        #2 n_rst = 1'b0;
        #1;
        total++;
        if ({serial_out, tx_if.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            bad++;
            $display("FAIL reset_immediate: line/ready/busy/done=%b%b%b%b required 1100",
                     serial_out, tx_if.tx_ready, tx_busy, tx_done);
        end
        tx_if.tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            total++;
            if ({serial_out, tx_if.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
                bad++;
                $display("FAIL reset_hold cycle=%0d: line/ready/busy/done=%b%b%b%b required 1100",
                         i, serial_out, tx_if.tx_ready, tx_busy, tx_done);
            end
        end
        tx_if.tx_valid = 1'b0;
        n_rst = 1'b1;
        @(negedge tb_clk);
        total++;
        if ({serial_out, tx_if.tx_ready, tx_busy} !== 3'b110) begin
            bad++;
            $display("FAIL reset_release_idle: line/ready/busy=%b%b%b required 110",
                     serial_out, tx_if.tx_ready, tx_busy);
        end
    endtask

    task automatic test_single_frame;
        run_frame(8'hA5, 8'hA5, 1'b0, FRAME + 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            total++;
            if ({serial_out, tx_if.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
                bad++;
                $display("FAIL single_idle_after cycle=%0d: line/ready/busy/done=%b%b%b%b required 1100",
                         i, serial_out, tx_if.tx_ready, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_hold_off;
        run_frame(8'hA5, 8'h3C, 1'b1, FRAME + 1);
        @(negedge tb_clk);
        run_frame(8'h3C, 8'h3C, 1'b0, FRAME + 1);
        @(negedge tb_clk);
    endtask

    task automatic test_back_to_back;
        int start_done;
        start_done = done_seen;
        run_frame(8'h00, 8'hFF, 1'b1, FRAME + 1);
        @(negedge tb_clk);
        run_frame(8'hFF, 8'h5A, 1'b1, FRAME + 1);
        tx_if.tx_valid = 1'b0;
        @(negedge tb_clk);
        total++;
        if (done_seen - start_done !== 2) begin
            bad++;
            $display("FAIL b2b_done_pulses: got %0d required 2", done_seen - start_done);
        end
    endtask

    task automatic test_clear;
        int start_done;
        logic [N-1:0] d1, d2;
        d1 = N'($urandom);
        d2 = N'($urandom);
        start_done = done_seen;
        run_frame(d1, d1, 1'b0, 4 * P + 4);
        clear          = 1'b1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = d2;
        @(negedge tb_clk);
        clear = 1'b0;
        total++;
        if ({serial_out, tx_if.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            bad++;
            $display("FAIL clear_next_cycle: line/ready/busy/done=%b%b%b%b required 1100",
                     serial_out, tx_if.tx_ready, tx_busy, tx_done);
        end
        run_frame(d2, d1, 1'b0, FRAME + 1);
        @(negedge tb_clk);
        total++;
        if (done_seen - start_done !== 1) begin
            bad++;
            $display("FAIL clear_done_pulses: got %0d required 1", done_seen - start_done);
        end
    endtask

    task automatic test_async_reset;
        int start_done;
        logic [N-1:0] d;
        d = N'($urandom);
        start_done = done_seen;
        run_frame(d, d, 1'b0, FRAME - 5);
        #2 n_rst = 1'b0;
        #1;
        total++;
        if ({serial_out, tx_if.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            bad++;
            $display("FAIL async_reset_immediate: line/ready/busy/done=%b%b%b%b required 1100",
                     serial_out, tx_if.tx_ready, tx_busy, tx_done);
        end
        repeat (8) @(negedge tb_clk);
        n_rst = 1'b1;
        total++;
        if (done_seen !== start_done) begin
            bad++;
            $display("FAIL async_reset_no_done: got %0d pulses required 0", done_seen - start_done);
        end
        d = N'($urandom);
        run_frame(d, ~d, 1'b0, FRAME + 1);
        @(negedge tb_clk);
    endtask

    task automatic test_random;
        logic [N-1:0] d;
        int unsigned gap;
        for (int k = 0; k < 5; k++) begin
            d   = N'($urandom);
            gap = $urandom_range(1, 4);
            run_frame(d, N'($urandom), 1'b0, FRAME + 1);
            for (int unsigned g = 0; g < gap; g++) begin
                @(negedge tb_clk);
                total++;
                if ({serial_out, tx_if.tx_ready, tx_busy, tx_done} !== 4'b1100) begin
                    bad++;
                    $display("FAIL random_gap k=%0d g=%0d: line/ready/busy/done=%b%b%b%b required 1100",
                             k, g, serial_out, tx_if.tx_ready, tx_busy, tx_done);
                end
            end
        end
    endtask

    initial begin
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        test_reset();
        test_single_frame();
        test_hold_off();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
